// File: rtl/pe_reconf_pkg.sv
// pe_reconf_pkg
// Shared types and constants for the PE partial-reconfiguration sequencer:
// the sequencer state encoding and the header length field location within
// a 64-bit flit.
package pe_reconf_pkg;

  localparam int FLIT_W  = 64;
  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GRANT,
    ST_BUSY,
    ST_RESET
  } state_e;

endpackage

// File: rtl/pe_pkt_track.sv
// pe_pkt_track
// Per-channel packet boundary tracker. Follows transferred beats only
// (valid_i=1, bp_i=0). A header carries the payload beat count in its length
// field; while payload beats remain the channel is "in a packet".
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   valid_i      beat valid (PE side)
//   bp_i         backpressure seen by the PE
//   clear_i      drop any tracked packet (PE is being reset)
//   len_i        header length field of the current beat
//   in_pkt_o     registered in-packet flag
//   in_pkt_nxt_o in-packet flag as it will be after this cycle
module pe_pkt_track
  import pe_reconf_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             bp_i,
  input  logic             clear_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             in_pkt_o,
  output logic             in_pkt_nxt_o
);

  logic [LEN_W-1:0] rem_q, rem_d;
  logic             in_pkt_q, in_pkt_d;
  logic             xfer;

  assign xfer = valid_i & ~bp_i;

  always_comb begin
    rem_d    = rem_q;
    in_pkt_d = in_pkt_q;
    if (clear_i) begin
      rem_d    = '0;
      in_pkt_d = 1'b0;
    end else if (xfer) begin
      if (in_pkt_q) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) in_pkt_d = 1'b0;
      end else if (len_i != '0) begin
        // Header with payload: a zero-length header is a complete packet.
        rem_d    = len_i;
        in_pkt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q    <= '0;
      in_pkt_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  assign in_pkt_o     = in_pkt_q;
  assign in_pkt_nxt_o = in_pkt_d;

endmodule

// File: rtl/pe_reconf_seq.sv
// pe_reconf_seq
// Makes partial reconfiguration of the PE safe: on a request it stops new PE
// packets at packet boundaries, lets in-flight packets finish, grants the
// ICAP, waits for the bitstream load, pulses the PE reset and then releases
// traffic. Data is a combinational wire-through; only valid/bp are gated,
// and the gating is derived from registered state.
//
// Optional feature: define PE_RECONF_TIMEOUT_EN to add a per-state watchdog
// (DRAIN/GRANT/BUSY) that forces the RESET phase and sets TIMEOUT_ERR.
//
// Ports:
//   CLK, RST_N       clock, synchronous active-low reset
//   RECONF_REQ       single-cycle reconfiguration request
//   RECONF_GNT       ICAP may drive the PE region
//   RECONF_DONE      single-cycle completion pulse
//   ICAP_BUSY        ICAP is loading the bitstream
//   SOF_RST          router PE reset, passed through to PE_RST
//   PE_RST           reset to the PE
//   PE_Q_IN/_VALID_IN, PE_Q_BP_OUT    PE side of the output channels
//   PE_Q_OUT/_VALID_OUT, PE_Q_BP_IN   router side of the output channels
//   TIMEOUT_ERR      sticky watchdog flag
module pe_reconf_seq
  import pe_reconf_pkg::*;
#(
  parameter int NumCh         = 2,
  parameter int RstCycles     = 16,
  parameter int TimeoutCycles = 65536
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    RECONF_REQ,
  output logic                    RECONF_GNT,
  output logic                    RECONF_DONE,
  input  logic                    ICAP_BUSY,
  input  logic                    SOF_RST,
  output logic                    PE_RST,
  input  logic [FLIT_W*NumCh-1:0] PE_Q_IN,
  input  logic [NumCh-1:0]        PE_Q_VALID_IN,
  output logic [NumCh-1:0]        PE_Q_BP_OUT,
  output logic [FLIT_W*NumCh-1:0] PE_Q_OUT,
  output logic [NumCh-1:0]        PE_Q_VALID_OUT,
  input  logic [NumCh-1:0]        PE_Q_BP_IN,
  output logic                    TIMEOUT_ERR
);

  localparam logic [7:0] RstLast = 8'(RstCycles);

  state_e           state_q, state_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic [NumCh-1:0] in_pkt, in_pkt_nxt, blk;
  logic             rst_pulse;
  logic             wd_fire;

  // RESET lasts RstCycles cycles of PE reset plus one blocked DONE cycle.
  assign rst_pulse   = (state_q == ST_RESET) && (rcnt_q != RstLast);
  assign PE_RST      = SOF_RST | rst_pulse;
  assign RECONF_DONE = (state_q == ST_RESET) && (rcnt_q == RstLast);
  assign RECONF_GNT  = (state_q == ST_GRANT) || (state_q == ST_BUSY);
  assign PE_Q_OUT    = PE_Q_IN;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    // During DRAIN only channels mid-packet may continue.
    assign blk[c] = (state_q == ST_DRAIN) ? ~in_pkt[c] : (state_q != ST_IDLE);
    assign PE_Q_VALID_OUT[c] = PE_Q_VALID_IN[c] & ~blk[c];
    assign PE_Q_BP_OUT[c]    = PE_Q_BP_IN[c] | blk[c];

    // A PE held in reset has no packet in flight, whatever its cause.
    pe_pkt_track u_track (
      .clk_i        (CLK),
      .rst_ni       (RST_N),
      .valid_i      (PE_Q_VALID_IN[c]),
      .bp_i         (PE_Q_BP_OUT[c]),
      .clear_i      (PE_RST),
      .len_i        (PE_Q_IN[c*FLIT_W+LEN_LSB +: LEN_W]),
      .in_pkt_o     (in_pkt[c]),
      .in_pkt_nxt_o (in_pkt_nxt[c])
    );
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = '0;
    unique case (state_q)
      ST_IDLE:  if (RECONF_REQ) state_d = ST_DRAIN;
      // Look at next-cycle in_pkt so GNT rises right after the last beat.
      ST_DRAIN: if (in_pkt_nxt == '0) state_d = ST_GRANT;
      ST_GRANT: if (ICAP_BUSY) state_d = ST_BUSY;
      ST_BUSY:  if (!ICAP_BUSY) state_d = ST_RESET;
      ST_RESET: begin
        rcnt_d = rcnt_q + 8'd1;
        if (rcnt_q == RstLast) begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    if (wd_fire) begin
      state_d = ST_RESET;
      rcnt_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

`ifdef PE_RECONF_TIMEOUT_EN
  localparam logic [31:0] WdLimit = 32'(TimeoutCycles - 1);

  logic [31:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic        wd_run;

  assign wd_run  = (state_q == ST_DRAIN) || (state_q == ST_GRANT) || (state_q == ST_BUSY);
  assign wd_fire = wd_run && (wd_q == WdLimit);

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_d != state_q) wd_d = '0;
    else if (wd_run)        wd_d = wd_q + 32'd1;
    if (wd_fire) err_d = 1'b1;
    else if ((state_q == ST_IDLE) && RECONF_REQ) err_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign TIMEOUT_ERR = err_q;
`else
  assign wd_fire = 1'b0;
  // No watchdog: the flag is constant 0 (a negative limit never occurs).
  assign TIMEOUT_ERR = (TimeoutCycles < 0);
`endif

endmodule

// File: tb/tb_pe_reconf_seq.sv
module tb_pe_reconf_seq;

  localparam int NCH     = 2;
  localparam int RST_CYC = 16;
  localparam int TO_CYC  = 64;

  logic             CLK = 1'b0;
  logic             RST_N, RECONF_REQ, ICAP_BUSY, SOF_RST;
  logic             RECONF_GNT, RECONF_DONE, PE_RST, TIMEOUT_ERR;
  logic [64*NCH-1:0] PE_Q_IN, PE_Q_OUT;
  logic [NCH-1:0]   PE_Q_VALID_IN, PE_Q_BP_OUT, PE_Q_VALID_OUT, PE_Q_BP_IN;

  pe_reconf_seq #(.NumCh(NCH), .RstCycles(RST_CYC), .TimeoutCycles(TO_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N), .RECONF_REQ(RECONF_REQ), .RECONF_GNT(RECONF_GNT),
    .RECONF_DONE(RECONF_DONE), .ICAP_BUSY(ICAP_BUSY), .SOF_RST(SOF_RST), .PE_RST(PE_RST),
    .PE_Q_IN(PE_Q_IN), .PE_Q_VALID_IN(PE_Q_VALID_IN), .PE_Q_BP_OUT(PE_Q_BP_OUT),
    .PE_Q_OUT(PE_Q_OUT), .PE_Q_VALID_OUT(PE_Q_VALID_OUT), .PE_Q_BP_IN(PE_Q_BP_IN),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #2 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_q[NCH][$];   // beats the router must see, in order, per channel
  bit d0, d1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every beat the router accepts must be the next expected one.
  always @(negedge CLK) begin
    for (int c = 0; c < NCH; c++) begin
      if (PE_Q_VALID_OUT[c] && !PE_Q_BP_IN[c]) begin
        if (exp_q[c].size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL beat_unexpected_ch%0d: got %0h want no beat", c, PE_Q_OUT[c*64 +: 64]);
        end else begin
          chk($sformatf("beat_ch%0d", c), PE_Q_OUT[c*64 +: 64], exp_q[c].pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Present one beat, hold it until the PE side sees it accepted.
  task automatic put_beat(input int ch, input logic [63:0] d, input bit req);
    bit ok = 0;
    PE_Q_IN[ch*64 +: 64] = d;
    PE_Q_VALID_IN[ch] = 1'b1;
    exp_q[ch].push_back(d);
    if (req) RECONF_REQ = 1'b1;
    for (int k = 0; k < 500; k++) begin
      smp();
      if (!PE_Q_BP_OUT[ch]) begin ok = 1; break; end
      step();
    end
    step();
    if (req) RECONF_REQ = 1'b0;
    PE_Q_VALID_IN[ch] = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_stall_ch%0d: got blocked want accepted", ch);
      void'(exp_q[ch].pop_back());
    end
  endtask

  task automatic send_pkt(input int ch, input int len);
    logic [63:0] hdr = {$urandom, $urandom};
    hdr[15:0] = 16'(len);
    put_beat(ch, hdr, 1'b0);
    for (int i = 0; i < len; i++) put_beat(ch, {$urandom, $urandom}, 1'b0);
  endtask

  // Request with no packets in flight: GNT must appear exactly 2 cycles later.
  task automatic req_expect_gnt();
    RECONF_REQ = 1'b1;
    smp(); chk("gnt_req_cycle", RECONF_GNT, 0);
    step(); RECONF_REQ = 1'b0;
    smp(); chk("gnt_drain_cycle", RECONF_GNT, 0);
    step();
    smp(); chk("gnt_2_after_req", RECONF_GNT, 1);
    step();
  endtask

  // Called at the start of the cycle after GNT rose. Drives the ICAP load
  // and checks the reset pulse, DONE pulse and traffic release.
  task automatic run_busy(input int delay, input int blen, input bit req_in_busy);
    repeat (delay - 1) step();
    ICAP_BUSY = 1'b1;
    for (int i = 0; i < blen; i++) begin
      RECONF_REQ = req_in_busy && (i == blen / 2);
      smp();
      if (i == 0 || i == blen - 1) chk("gnt_while_loading", RECONF_GNT, 1);
      step();
    end
    RECONF_REQ = 1'b0;
    ICAP_BUSY = 1'b0;
    smp(); chk("pe_rst_before_reset", PE_RST, 0);
    for (int i = 0; i < RST_CYC; i++) begin
      step(); smp();
      chk("pe_rst_on", PE_RST, 1);
      if (i == 0) chk("blocked_in_reset", PE_Q_VALID_OUT, 0);
      if (i == RST_CYC - 1) chk("done_early", RECONF_DONE, 0);
    end
    step(); smp();
    chk("done_pulse", RECONF_DONE, 1);
    chk("pe_rst_off_at_done", PE_RST, 0);
    chk("gnt_off_at_done", RECONF_GNT, 0);
    chk("blocked_at_done", PE_Q_BP_OUT, {NCH{1'b1}});
    step(); smp();
    chk("done_single", RECONF_DONE, 0);
    chk("traffic_resumed", PE_Q_BP_OUT, PE_Q_BP_IN);
    repeat (4) step();
    smp(); chk("no_second_sequence", RECONF_GNT, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "time limit");
  end

  initial begin
    RST_N = 1'b0; RECONF_REQ = 1'b0; ICAP_BUSY = 1'b0; SOF_RST = 1'b0;
    PE_Q_IN = '0; PE_Q_VALID_IN = '0; PE_Q_BP_IN = 2'b10;
    step(); step();
    smp();
    chk("rst_gnt", RECONF_GNT, 0);
    chk("rst_done", RECONF_DONE, 0);
    chk("rst_timeout_err", TIMEOUT_ERR, 0);
    chk("rst_pe_rst", PE_RST, 0);
    chk("rst_bp_pass", PE_Q_BP_OUT, 2'b10);
    step();
    SOF_RST = 1'b1;
    smp(); chk("pe_rst_follows_sof", PE_RST, 1);
    step();
    SOF_RST = 1'b0; RST_N = 1'b1; PE_Q_BP_IN = '0;
    step();

    // Idle traffic: one len=3 packet passes unchanged.
    send_pkt(0, 3);
    step();
    chk("idle_all_beats_out", 64'(exp_q[0].size()), 0);
    smp(); chk("idle_pe_rst", PE_RST, 0);
    step();

    // Random packets on both channels with random router backpressure.
    d0 = 0; d1 = 0;
    fork
      begin for (int p = 0; p < 8; p++) send_pkt(0, $urandom_range(0, 4)); d0 = 1; end
      begin for (int p = 0; p < 8; p++) send_pkt(1, $urandom_range(0, 4)); d1 = 1; end
      begin while (!(d0 && d1)) begin PE_Q_BP_IN = 2'($urandom); step(); end end
    join
    PE_Q_BP_IN = '0;
    step();

    // Drain: request on the header of a len=5 packet on ch0.
    begin
      logic [63:0] hdr = {$urandom, $urandom};
      logic [63:0] hdr1 = {$urandom, $urandom};
      hdr[15:0] = 16'd5;
      hdr1[15:0] = 16'd0;
      put_beat(0, hdr, 1'b1);
      fork put_beat(1, hdr1, 1'b0); join_none
      for (int i = 0; i < 5; i++) begin
        PE_Q_IN[63:0] = {$urandom, $urandom};
        PE_Q_VALID_IN[0] = 1'b1;
        exp_q[0].push_back(PE_Q_IN[63:0]);
        smp();
        chk("drain_payload_passes", PE_Q_BP_OUT[0], 0);
        chk("drain_new_header_blocked", PE_Q_BP_OUT[1], 1);
        chk("drain_gnt_low", RECONF_GNT, 0);
        step();
      end
      PE_Q_VALID_IN[0] = 1'b0;
      smp(); chk("gnt_after_last_beat", RECONF_GNT, 1);
      step();
      run_busy(2, 5, 1'b0);
      wait fork;
    end
    step();

    // Full sequence with idle channels; a request during BUSY is ignored.
    req_expect_gnt();
    run_busy(3, 100, 1'b1);

    // SOF_RST pulse in IDLE clears a half-received packet.
    begin
      logic [63:0] hdr = {$urandom, $urandom};
      hdr[15:0] = 16'd4;
      put_beat(0, hdr, 1'b0);
      put_beat(0, {$urandom, $urandom}, 1'b0);
      put_beat(0, {$urandom, $urandom}, 1'b0);
      SOF_RST = 1'b1;
      for (int i = 0; i < 5; i++) begin smp(); chk("sof_pe_rst", PE_RST, 1); step(); end
      SOF_RST = 1'b0;
      smp(); chk("sof_pe_rst_end", PE_RST, 0);
      step();
      req_expect_gnt();
      run_busy(2, 4, 1'b0);
    end

    // RST_N during BUSY returns to pass-through at once.
    req_expect_gnt();
    ICAP_BUSY = 1'b1;
    repeat (3) step();
    smp(); chk("busy_gnt", RECONF_GNT, 1);
    step();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    PE_Q_BP_IN = 2'b01;
    smp();
    chk("rstn_gnt_off", RECONF_GNT, 0);
    chk("rstn_passthrough", PE_Q_BP_OUT, 2'b01);
    step();
    PE_Q_BP_IN = '0;
    ICAP_BUSY = 1'b0;
    send_pkt(1, 2);
    req_expect_gnt();
    run_busy(2, 4, 1'b0);

`ifdef PE_RECONF_TIMEOUT_EN
    // Watchdog: ICAP never starts.
    req_expect_gnt();
    repeat (TO_CYC - 2) step();
    smp(); chk("to_err_before", TIMEOUT_ERR, 0);
    step();
    smp();
    chk("to_err_set", TIMEOUT_ERR, 1);
    chk("to_pe_rst", PE_RST, 1);
    repeat (RST_CYC) step();
    smp(); chk("to_done", RECONF_DONE, 1);
    step(); step();
    RECONF_REQ = 1'b1;
    smp(); chk("to_err_sticky", TIMEOUT_ERR, 1);
    step();
    RECONF_REQ = 1'b0;
    smp(); chk("to_err_cleared", TIMEOUT_ERR, 0);
    step();
    smp(); chk("to_gnt_again", RECONF_GNT, 1);
    step();
    run_busy(3, 5, 1'b0);
`endif

    step();
    for (int c = 0; c < NCH; c++) chk($sformatf("beats_left_ch%0d", c), 64'(exp_q[c].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
